// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Operand/result handshake bundle between producer, subtractor and consumer.
interface serial_subtractor_ctrl_if
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             abort;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             busy;

   modport master (
      output in_valid, a, b, borrow_in, abort, out_ready,
      input  in_ready, out_valid, diff, borrow_out, busy
   );

   modport slave (
      input  in_valid, a, b, borrow_in, abort, out_ready,
      output in_ready, out_valid, diff, borrow_out, busy
   );
endinterface

// File: rtl/fs_bit_cell.sv
// One-bit full subtractor: d = x - y - bi, bo = borrow out.
module fs_bit_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);
   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - borrow_in, LSB first, over WIDTH cycles with valid/ready on both sides.
// Optional build macro SERIAL_SUB_SATURATE_EN clamps an underflowing result to zero.
module serial_subtractor_ctrl
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic                     clk,
   input logic                     rst_n,
   serial_subtractor_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, diff_q, diff_shifted;
   logic [CNT_W-1:0] cnt;
   logic             borrow_q, borrow_out_q;
   logic             in_ready_q, out_valid_q, busy_q;
   logic             load_c, shift_c, last_c;
   logic             d_bit, br_bit;

   fs_bit_cell u_cell (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .bi (borrow_q),
      .d  (d_bit),
      .bo (br_bit)
   );

   // Next state and datapath enables; abort outranks completion and handoff.
   always_comb begin
      state_nxt = state;
      load_c    = 1'b0;
      shift_c   = 1'b0;
      last_c    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               load_c    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else begin
               shift_c = 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  last_c    = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (bus.abort || bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef SERIAL_SUB_SATURATE_EN
   // Unsigned floor: an underflowing result is reported as zero.
   assign diff_shifted = (last_c && br_bit) ? '0 : {d_bit, diff_q[WIDTH-1:1]};
`else
   assign diff_shifted = {d_bit, diff_q[WIDTH-1:1]};
`endif

   // State and handshake flags registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         in_ready_q  <= (state_nxt == IDLE);
         out_valid_q <= (state_nxt == DONE);
         busy_q      <= (state_nxt != IDLE);
      end
   end

   // Operand shifters, result shifter, borrow chain and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh         <= '0;
         b_sh         <= '0;
         diff_q       <= '0;
         borrow_q     <= 1'b0;
         borrow_out_q <= 1'b0;
         cnt          <= '0;
      end else if (load_c) begin
         a_sh     <= bus.a;
         b_sh     <= bus.b;
         borrow_q <= bus.borrow_in;
         cnt      <= '0;
      end else if (shift_c) begin
         a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
         diff_q   <= diff_shifted;
         borrow_q <= br_bit;
         cnt      <= cnt + CNT_W'(1);
         if (last_c) begin
            borrow_out_q <= br_bit;
         end
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = busy_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random checks of serial_subtractor_ctrl against an arithmetic reference.
module tb_serial_subtractor_ctrl;
   localparam int unsigned W = 8;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

   serial_subtractor_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer subtraction, result modulo 2^W, borrow on negative.
   function automatic logic [W:0] ref_sub(input int a, input int b, input int bi);
      int  r;
      logic br;
      logic [W-1:0] d;
      r  = a - b - bi;
      br = (r < 0);
      d  = W'((r + (1 << (W + 1))) % (1 << W));
`ifdef SERIAL_SUB_SATURATE_EN
      if (br) d = '0;
`endif
      return {br, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands until accepted; returns with the accepting edge just past.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      int n;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      check("in_ready_before_op", 32'(bus.in_ready), 32'd1);
      bus.a = a; bus.b = b; bus.borrow_in = bi; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("busy_after_accept", 32'(bus.busy), 32'd1);
   endtask

   // Counts edges until out_valid (from accept), then checks result and hands it off.
   task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic bi, input int already, input int stall);
      int lat;
      logic [W:0] exp;
      exp = ref_sub(int'(a), int'(b), int'(bi));
      lat = already;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(W));
      check({tag, "_diff"}, 32'(bus.diff), 32'(exp[W-1:0]));
      check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(exp[W]));
      repeat (stall) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_idle_after"}, 32'({bus.out_valid, bus.busy, bus.in_ready}), 32'b001);
      check({tag, "_diff_hold"}, 32'(bus.diff), 32'(exp[W-1:0]));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic rbi;
      logic [W:0] e;
      int errs;
      total = 0; bad = 0;
      bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.borrow_in = 0;
      bus.abort = 0; bus.out_ready = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("reset_flags", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
      check("reset_data", 32'({bus.borrow_out, bus.diff}), 32'd0);

      // Directed vectors.
      start_op(8'd5, 8'd3, 1'b0);     finish_op("v5m3", 8'd5, 8'd3, 1'b0, 0, 0);
      e = ref_sub(5, 3, 0);
      check("v5m3_known", 32'(e), 32'h002);
      start_op(8'd3, 8'd5, 1'b0);     finish_op("v3m5", 8'd3, 8'd5, 1'b0, 0, 0);
      start_op(8'd0, 8'd0, 1'b1);     finish_op("v0m0b", 8'd0, 8'd0, 1'b1, 0, 0);
      start_op(8'hA5, 8'hA5, 1'b0);   finish_op("vA5", 8'hA5, 8'hA5, 1'b0, 0, 0);

      // Stall in DONE with competing operands on the input side.
      start_op(8'd100, 8'd37, 1'b1);
      repeat (W) tick();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      e = ref_sub(100, 37, 1);
      bus.a = 8'd1; bus.b = 8'd2; bus.borrow_in = 1'b0; bus.in_valid = 1'b1;
      errs = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== e[W-1:0]
             || bus.borrow_out !== e[W]) errs++;
      end
      check("stall_hold", 32'(errs), 32'd0);
      bus.in_valid = 1'b0;
      finish_op("stall", 8'd100, 8'd37, 1'b1, W, 0);

      // Abort in SHIFT at bit 4: no result, then a clean op.
      start_op(8'd77, 8'd9, 1'b0);
      repeat (4) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_idle", 32'({bus.in_ready, bus.busy, bus.out_valid}), 32'b100);
      errs = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.out_valid !== 1'b0) errs++;
      end
      check("abort_no_valid", 32'(errs), 32'd0);
      start_op(8'd200, 8'd55, 1'b0);  finish_op("post_abort", 8'd200, 8'd55, 1'b0, 0, 0);

      // Abort in DONE outranks out_ready.
      start_op(8'd10, 8'd20, 1'b0);
      repeat (W) tick();
      bus.abort = 1'b1; bus.out_ready = 1'b1;
      tick();
      bus.abort = 1'b0; bus.out_ready = 1'b0;
      check("abort_done", 32'({bus.in_ready, bus.busy, bus.out_valid}), 32'b100);

      // Asynchronous reset mid-operation.
      start_op(8'd255, 8'd1, 1'b1);
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", 32'({bus.out_valid, bus.busy, bus.borrow_out, bus.diff}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("reset_release_ready", 32'(bus.in_ready), 32'd1);

      // Random operands with random consumer back-pressure.
      for (int k = 0; k < 25; k++) begin
         ra  = W'($urandom_range(0, (1 << W) - 1));
         rb  = W'($urandom_range(0, (1 << W) - 1));
         rbi = 1'($urandom_range(0, 1));
         start_op(ra, rb, rbi);
         finish_op("rand", ra, rb, rbi, 0, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
